// File: rtl/mips_pc_pkg.sv
// ============================================================================
// Module : mips_pc_pkg
// Brief  : Shared widths, reset default and sequencer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pc_pkg;
  localparam int PC_W      = 32;
  localparam int JTARGET_W = 26;
  localparam int BOFF_W    = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    SLOT   = 1'b1
  } pc_state_e;
endpackage

`default_nettype wire

// File: rtl/mips_next_pc_if.sv
// ============================================================================
// Module : mips_next_pc_if
// Brief  : Control-side request bundle and PC-side results of the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mips_next_pc_if;
  import mips_pc_pkg::*;

  logic                 stall;
  logic                 jump;
  logic [JTARGET_W-1:0] jump_target;
  logic                 branch;
  logic [BOFF_W-1:0]    branch_offset;
  logic                 jr;
  logic [PC_W-1:0]      jr_addr;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pc_plus4;
  logic                 in_slot;
  logic                 align_err;
  logic                 slot_violation;

  modport master (
    output stall, jump, jump_target, branch, branch_offset, jr, jr_addr,
    input  pc, pc_plus4, in_slot, align_err, slot_violation
  );

  modport slave (
    input  stall, jump, jump_target, branch, branch_offset, jr, jr_addr,
    output pc, pc_plus4, in_slot, align_err, slot_violation
  );
endinterface

`default_nettype wire

// File: rtl/mips_pc_target.sv
// ============================================================================
// Module : mips_pc_target
// Brief  : Combinational successor candidates and jr > jump > branch > seq pick.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mips_pc_target
  import mips_pc_pkg::*;
(
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 jump_i,
  input  logic [JTARGET_W-1:0] jump_target_i,
  input  logic                 branch_i,
  input  logic [BOFF_W-1:0]    branch_offset_i,
  input  logic                 jr_i,
  input  logic [PC_W-1:0]      jr_addr_i,
  output logic [PC_W-1:0]      pc_plus4_o,
  output logic [PC_W-1:0]      tgt_o,
  output logic                 redirect_o,
  output logic                 misalign_o
);
  logic [PC_W-1:0] w_br;
  logic [PC_W-1:0] w_j;
  logic [PC_W-1:0] w_jra;

  assign pc_plus4_o = pc_i + PC_W'(4);
  assign w_br  = pc_plus4_o + {{(PC_W-BOFF_W-2){branch_offset_i[BOFF_W-1]}},
                               branch_offset_i, 2'b00};
  // Jump region comes from the delay-slot address, not the jump itself.
  assign w_j   = {pc_plus4_o[PC_W-1:PC_W-4], jump_target_i, 2'b00};
  assign w_jra = {jr_addr_i[PC_W-1:2], 2'b00};

  assign redirect_o = jr_i | jump_i | branch_i;
  assign misalign_o = jr_i & (|jr_addr_i[1:0]);

  always_comb begin
    tgt_o = pc_plus4_o;
    if (jr_i)          tgt_o = w_jra;
    else if (jump_i)   tgt_o = w_j;
    else if (branch_i) tgt_o = w_br;
  end
endmodule

`default_nettype wire

// File: rtl/mips_next_pc.sv
// ============================================================================
// Module : mips_next_pc
// Brief  : PC register and redirect sequencing; MIPS_DELAY_SLOT_EN adds the
//          branch-delay-slot FSM, slot_target latch and slot_violation flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mips_next_pc
  import mips_pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_next_pc_if.slave  ctl_if
);
  logic [PC_W-1:0] pc_q;
  logic            align_err_q;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_tgt;
  logic            w_redirect;
  logic            w_misalign;

  mips_pc_target u_target (
    .pc_i            (pc_q),
    .jump_i          (ctl_if.jump),
    .jump_target_i   (ctl_if.jump_target),
    .branch_i        (ctl_if.branch),
    .branch_offset_i (ctl_if.branch_offset),
    .jr_i            (ctl_if.jr),
    .jr_addr_i       (ctl_if.jr_addr),
    .pc_plus4_o      (w_pc_plus4),
    .tgt_o           (w_tgt),
    .redirect_o      (w_redirect),
    .misalign_o      (w_misalign)
  );

  assign ctl_if.pc        = pc_q;
  assign ctl_if.pc_plus4  = w_pc_plus4;
  assign ctl_if.align_err = align_err_q;

`ifdef MIPS_DELAY_SLOT_EN
  pc_state_e       state_q;
  logic [PC_W-1:0] slot_target_q;
  logic            slot_violation_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      state_q          <= NORMAL;
      slot_target_q    <= '0;
      align_err_q      <= 1'b0;
      slot_violation_q <= 1'b0;
    end else if (ctl_if.stall) begin
      align_err_q      <= 1'b0;
      slot_violation_q <= 1'b0;
    end else begin
      align_err_q      <= w_misalign;
      slot_violation_q <= 1'b0;
      case (state_q)
        NORMAL: begin
          pc_q <= w_pc_plus4;
          if (w_redirect) begin
            slot_target_q <= w_tgt;
            state_q       <= SLOT;
          end
        end
        SLOT: begin
          // First redirect wins; anything requested from the slot is dropped.
          pc_q             <= slot_target_q;
          state_q          <= NORMAL;
          slot_violation_q <= w_redirect;
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

  assign ctl_if.in_slot        = (state_q == SLOT);
  assign ctl_if.slot_violation = slot_violation_q;
`else
  logic [PC_W-1:0] pc_d;

  assign pc_d = w_redirect ? w_tgt : w_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else if (ctl_if.stall) begin
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= w_misalign;
    end
  end

  assign ctl_if.in_slot        = 1'b0;
  assign ctl_if.slot_violation = 1'b0;
`endif
endmodule

`default_nettype wire
